// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Definitions shared by the MAC datapath arithmetic blocks: the 24-bit
// carry-select adder and its companion, the 24-bit pipelined subtractor.
//   MAC_ACC_W      : accumulator / operand width
//   MAC_CSEL_SPLIT : bit position where the low carry-select half ends
//   acc_t          : accumulator-width vector type
// -----------------------------------------------------------------------------
package mac_pkg;
  localparam int MAC_ACC_W      = 24;
  localparam int MAC_CSEL_SPLIT = 12;

  typedef logic [MAC_ACC_W-1:0] acc_t;
endpackage

// File: rtl/sub_24bit_pipe_if.sv
// -----------------------------------------------------------------------------
// sub_24bit_pipe_if
// Operand/result handshake bundle of the pipelined subtractor.
//   in_valid/in_ready   : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, bout, sat)
// Modports:
//   master : the producer of operands and consumer of results (testbench / MAC)
//   slave  : the subtractor itself
// -----------------------------------------------------------------------------
interface sub_24bit_pipe_if
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_ACC_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             sat;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, sat
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, sat
  );
endinterface

// File: rtl/sub_24bit_pipe_csel.sv
// -----------------------------------------------------------------------------
// csel_half_sub
// Combinational carry-select half: adds an N-bit a to an already inverted
// subtrahend b_n for both possible carry-ins at once.
//   a, b_n     : N-bit operand and inverted subtrahend
//   sum0, c0   : a + b_n     and its carry-out
//   sum1, c1   : a + b_n + 1 and its carry-out
// -----------------------------------------------------------------------------
module csel_half_sub #(
  parameter int N = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b_n,
  output logic [N-1:0] sum0,
  output logic         c0,
  output logic [N-1:0] sum1,
  output logic         c1
);
  always_comb begin
    {c0, sum0} = {1'b0, a} + {1'b0, b_n};
    {c1, sum1} = {1'b0, a} + {1'b0, b_n} + {{N{1'b0}}, 1'b1};
  end
endmodule

// File: rtl/sub_24bit_pipe.sv
// -----------------------------------------------------------------------------
// sub_24bit_pipe
// Two-stage pipelined carry-select subtractor: diff = (a - b - bin) mod 2^WIDTH,
// bout = 1 when a < b + bin. Implemented as a + ~b + !bin; the final carry-out
// inverted is the borrow.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sub_24bit_pipe_if.slave (operand and result valid/ready handshakes)
// Stage 1 registers the low half and both candidate high halves; stage 2
// selects the high half with the low carry and registers the result.
// Optional build macro SUB_24BIT_PIPE_SAT_EN: unsigned saturating subtract,
// diff clamps to 0 and sat = 1 whenever the borrow is set. Without it sat = 0.
// -----------------------------------------------------------------------------
module sub_24bit_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_ACC_W,
  parameter int SPLIT = MAC_CSEL_SPLIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sub_24bit_pipe_if.slave       bus
);
  localparam int HW = WIDTH - SPLIT;

  // Combinational carry-select halves
  logic [SPLIT-1:0] lo_sum0, lo_sum1;
  logic             lo_c0, lo_c1;
  logic [HW-1:0]    hi_sum0, hi_sum1;
  logic             hi_c0, hi_c1;

  csel_half_sub #(.N(SPLIT)) u_lo (
    .a    (bus.a[SPLIT-1:0]),
    .b_n  (~bus.b[SPLIT-1:0]),
    .sum0 (lo_sum0),
    .c0   (lo_c0),
    .sum1 (lo_sum1),
    .c1   (lo_c1)
  );

  csel_half_sub #(.N(HW)) u_hi (
    .a    (bus.a[WIDTH-1:SPLIT]),
    .b_n  (~bus.b[WIDTH-1:SPLIT]),
    .sum0 (hi_sum0),
    .c0   (hi_c0),
    .sum1 (hi_sum1),
    .c1   (hi_c1)
  );

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
  logic             s1_cl_q, s1_cl_d;
  logic [HW-1:0]    s1_hi0_q, s1_hi0_d;
  logic [HW-1:0]    s1_hi1_q, s1_hi1_d;
  logic             s1_c0_q, s1_c0_d;
  logic             s1_c1_q, s1_c1_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             sat_q, sat_d;

  logic s1_ready, s2_ready;
  logic s1_load, s2_load;

  // Handshake: a stage may accept when empty or when it is emptied this cycle.
  always_comb begin
    s2_ready = !out_valid_q || bus.out_ready;
    s1_ready = !s1_valid_q || s2_ready;
    s1_load  = bus.in_valid && s1_ready;
    s2_load  = s1_valid_q && s2_ready;
  end

  always_comb begin
    logic [HW-1:0]    hi_sel;
    logic             c_sel;
    logic [WIDTH-1:0] raw;

    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_cl_d     = s1_cl_q;
    s1_hi0_d    = s1_hi0_q;
    s1_hi1_d    = s1_hi1_q;
    s1_c0_d     = s1_c0_q;
    s1_c1_d     = s1_c1_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    sat_d       = sat_q;

    hi_sel = s1_cl_q ? s1_hi1_q : s1_hi0_q;
    c_sel  = s1_cl_q ? s1_c1_q  : s1_c0_q;
    raw    = {hi_sel, s1_lo_q};

    if (s1_ready) begin
      s1_valid_d = bus.in_valid;
    end
    if (s1_load) begin
      // Low carry-in is !bin: select the +1 result when there is no borrow-in.
      s1_lo_d  = bus.bin ? lo_sum0 : lo_sum1;
      s1_cl_d  = bus.bin ? lo_c0   : lo_c1;
      s1_hi0_d = hi_sum0;
      s1_hi1_d = hi_sum1;
      s1_c0_d  = hi_c0;
      s1_c1_d  = hi_c1;
    end

    if (s2_ready) begin
      out_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      bout_d = !c_sel;
`ifdef SUB_24BIT_PIPE_SAT_EN
      diff_d = c_sel ? raw : '0;
      sat_d  = !c_sel;
`else
      diff_d = raw;
      sat_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_cl_q     <= 1'b0;
      s1_hi0_q    <= '0;
      s1_hi1_q    <= '0;
      s1_c0_q     <= 1'b0;
      s1_c1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_cl_q     <= s1_cl_d;
      s1_hi0_q    <= s1_hi0_d;
      s1_hi1_q    <= s1_hi1_d;
      s1_c0_q     <= s1_c0_d;
      s1_c1_q     <= s1_c1_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.sat       = sat_q;
endmodule
